detection_event_logger: RTL and testbench

DETECTION_EVENT_LOGGER -- requirements
Module: detection_event_logger

---
 rtl/detection_event_logger_pkg.sv | 10 +
 rtl/detection_event_logger_sync_fifo.sv | 55 +++++
 rtl/detection_event_logger.sv | 61 ++++++
 tb/tb_detection_event_logger.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/detection_event_logger_pkg.sv
// Shared defaults for the detection event logger: timestamp/depth sizing and
// the saturating detection-counter width.
package detection_event_logger_pkg;

   localparam int unsigned TS_W_DEFAULT  = 8;
   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam int unsigned CNT_W         = 8;
   localparam logic [CNT_W-1:0] CNT_MAX  = 8'd255;

endpackage

// File: rtl/detection_event_logger_sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-around pointers and a
// separate occupancy count; the head reads as zero whenever the FIFO is empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_rd;
   logic             w_wr;

   assign w_rd = rd_en && (r_level != '0);
   // A push into a full FIFO is legal only alongside a pop; the write then
   // lands in the slot being vacated by that pop.
   assign w_wr = wr_en && ((r_level != FULL_LVL) || w_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         if (w_wr && !w_rd)      r_level <= r_level + 1'b1;
         else if (!w_wr && w_rd) r_level <= r_level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr) r_mem[r_wptr] <= din;
   end

   assign empty = (r_level == '0);
   assign full  = (r_level == FULL_LVL);
   assign level = r_level;
   assign dout  = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/detection_event_logger.sv
// Timestamps detection pulses into a small FIFO; counts every detection
// (saturating) and flags any event dropped because the FIFO was full.
module detection_event_logger
   import detection_event_logger_pkg::*;
#(
   parameter int unsigned TS_W  = TS_W_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec,
   input  logic                     rd_en,
   output logic [TS_W-1:0]          ts_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         det_cnt,
   output logic                     ovf
);

   logic [TS_W-1:0]  r_ts;
   logic [CNT_W-1:0] r_det_cnt;
   logic             r_ovf;
   logic             w_push;
   logic             w_drop;

   // When full, a pop on the same edge frees the slot so the event is kept.
   assign w_push = dec && (!full || rd_en);
   assign w_drop = dec && full && !rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ts      <= '0;
         r_det_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (dec && (r_det_cnt != CNT_MAX)) r_det_cnt <= r_det_cnt + 1'b1;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (w_push),
      .rd_en (rd_en),
      .din   (r_ts),
      .dout  (ts_out),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   assign det_cnt = r_det_cnt;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_detection_event_logger.sv
// Directed bench for detection_event_logger: per-edge vector table plus
// hand-written timestamp-wrap and counter-saturation sequences.
module tb_detection_event_logger;

   logic       clk;
   logic       rst;
   logic       dec;
   logic       rd_en;
   logic [7:0] ts_out;
   logic       empty;
   logic       full;
   logic [2:0] level;
   logic [7:0] det_cnt;
   logic       ovf;

   int unsigned n_tests;
   int unsigned n_fail;

   typedef struct {
      logic        rst;
      logic        dec;
      logic        rd;
      logic        e;
      logic        f;
      int unsigned lvl;
      int unsigned ts;
      int unsigned cnt;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   detection_event_logger #(
      .TS_W  (8),
      .DEPTH (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .dec     (dec),
      .rd_en   (rd_en),
      .ts_out  (ts_out),
      .empty   (empty),
      .full    (full),
      .level   (level),
      .det_cnt (det_cnt),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic d, input logic rd,
                      input logic e, input logic f, input int unsigned lvl,
                      input int unsigned ts, input int unsigned cnt, input logic o);
      vec_t v;
      v.rst = r; v.dec = d; v.rd = rd; v.e = e; v.f = f;
      v.lvl = lvl; v.ts = ts; v.cnt = cnt; v.ovf = o;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one edge's inputs, then settle just past the edge for sampling.
   task automatic apply(input logic r, input logic d, input logic rd);
      rst = r; dec = d; rd_en = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; dec = 1'b0; rd_en = 1'b0;

      // Reset, then 10 idle edges.
      add(1,0,0, 1,0,0,0,0,0);
      for (int i = 0; i < 10; i++) add(0,0,0, 1,0,0,0,0,0);

      // Events at ts 3 and 7, then pops; extra pop on empty is ignored.
      add(1,0,0, 1,0,0,0,0,0);
      for (int i = 0; i < 3; i++) add(0,0,0, 1,0,0,0,0,0);
      add(0,1,0, 0,0,1,3,1,0);
      for (int i = 0; i < 3; i++) add(0,0,0, 0,0,1,3,1,0);
      add(0,1,0, 0,0,2,3,2,0);
      add(0,0,1, 0,0,1,7,2,0);
      add(0,0,1, 1,0,0,0,2,0);
      add(0,0,1, 1,0,0,0,2,0);

      // Five back-to-back events: fifth is dropped.
      add(1,0,0, 1,0,0,0,0,0);
      add(0,1,0, 0,0,1,0,1,0);
      add(0,1,0, 0,0,2,0,2,0);
      add(0,1,0, 0,0,3,0,3,0);
      add(0,1,0, 0,1,4,0,4,0);
      add(0,1,0, 0,1,4,0,5,1);
      add(0,0,1, 0,0,3,1,5,1);
      add(0,0,1, 0,0,2,2,5,1);
      add(0,0,1, 0,0,1,3,5,1);
      add(0,0,1, 1,0,0,0,5,1);

      // Full FIFO with simultaneous push/pop at ts 20, then mid-level push/pop.
      add(1,0,0, 1,0,0,0,0,0);
      for (int i = 0; i < 16; i++) add(0,0,0, 1,0,0,0,0,0);
      add(0,1,0, 0,0,1,16,1,0);
      add(0,1,0, 0,0,2,16,2,0);
      add(0,1,0, 0,0,3,16,3,0);
      add(0,1,0, 0,1,4,16,4,0);
      add(0,1,1, 0,1,4,17,5,0);
      add(0,0,1, 0,0,3,18,5,0);
      add(0,0,1, 0,0,2,19,5,0);
      add(0,1,1, 0,0,2,20,6,0);
      add(0,0,1, 0,0,1,23,6,0);
      add(0,0,1, 1,0,0,0,6,0);
      add(0,1,1, 0,0,1,26,7,0);
      add(0,0,1, 1,0,0,0,7,0);

      // Mid-operation reset with level 3, ovf set and dec on the reset edge.
      add(1,0,0, 1,0,0,0,0,0);
      add(0,1,0, 0,0,1,0,1,0);
      add(0,1,0, 0,0,2,0,2,0);
      add(0,1,0, 0,0,3,0,3,0);
      add(0,1,0, 0,1,4,0,4,0);
      add(0,1,0, 0,1,4,0,5,1);
      add(0,0,1, 0,0,3,1,5,1);
      add(1,1,0, 1,0,0,0,0,0);
      add(0,0,0, 1,0,0,0,0,0);
      add(0,1,0, 0,0,1,1,1,0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].dec, vecs[i].rd);
         check($sformatf("v%0d.empty", i),   32'(empty),   32'(vecs[i].e));
         check($sformatf("v%0d.full", i),    32'(full),    32'(vecs[i].f));
         check($sformatf("v%0d.level", i),   32'(level),   vecs[i].lvl);
         check($sformatf("v%0d.ts_out", i),  32'(ts_out),  vecs[i].ts);
         check($sformatf("v%0d.det_cnt", i), 32'(det_cnt), vecs[i].cnt);
         check($sformatf("v%0d.ovf", i),     32'(ovf),     32'(vecs[i].ovf));
      end

      // Timestamp wrap: events at 254 and, after wrapping, at 1.
      apply(1,0,0);
      for (int i = 0; i < 254; i++) apply(0,0,0);
      apply(0,1,0);
      apply(0,0,0);
      apply(0,0,0);
      apply(0,1,0);
      check("wrap.level", 32'(level), 2);
      check("wrap.head0", 32'(ts_out), 254);
      apply(0,0,1);
      check("wrap.head1", 32'(ts_out), 1);
      apply(0,0,1);
      check("wrap.empty", 32'(empty), 1);

      // 300 detections with continuous reads: counter saturates at 255.
      apply(1,0,0);
      for (int i = 0; i < 300; i++) begin
         apply(0,1,1);
         if (i == 253) check("sat.cnt254", 32'(det_cnt), 254);
         if (i == 254) check("sat.cnt255", 32'(det_cnt), 255);
      end
      check("sat.cnt", 32'(det_cnt), 255);
      check("sat.level", 32'(level), 1);
      check("sat.ovf", 32'(ovf), 0);
      check("sat.head", 32'(ts_out), 299 % 256);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
